// File: rtl/screen_sequencer.sv
// screen_sequencer: page controller for the VGA game display.
// Runs the TITLE/LEVEL/DONE page FSM, tracks the current level and muxes the
// page renderers' rgb onto the registered VGA output.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   video_on, x, y          raster position from the VGA sync counter
//   start                   debounced start button (level), edge-detected here
//   level_solved            one-cycle pulse from game logic
//   rgb_title/level/done    page renderer colours
//   rgb                     registered output colour (1-cycle latency)
//   page, level             current page (0 TITLE, 1 LEVEL, 2 DONE), level index
//   page_changed            one-cycle pulse when page or level is written
module screen_sequencer #(
    parameter int NUM_LEVELS       = 3,
    parameter int DONE_HOLD_FRAMES = 600,
    parameter int V_ACTIVE         = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        start,
    input  logic        level_solved,
    input  logic [11:0] rgb_title,
    input  logic [11:0] rgb_level,
    input  logic [11:0] rgb_done,
    output logic [11:0] rgb,
    output logic [1:0]  page,
    output logic [2:0]  level,
    output logic        page_changed
);

    localparam int CW = (DONE_HOLD_FRAMES > 1) ? $clog2(DONE_HOLD_FRAMES) : 1;
    localparam logic [2:0]    LAST_LEVEL = 3'(NUM_LEVELS - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(DONE_HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        PAGE_TITLE = 2'd0,
        PAGE_LEVEL = 2'd1,
        PAGE_DONE  = 2'd2
    } page_e;

    page_e         page_q, page_d;
    logic [2:0]    level_q, level_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          go_req_q, go_req_d;
    logic          adv_req_q, adv_req_d;
    logic          changed_q, changed_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          vb_q;
    logic          start_q;

    logic vb;
    logic tick;
    logic start_rise;
    logic xfer;

    // One tick per frame even if x lingers at 0 on the first blank line.
    assign vb         = (x == 10'd0) && (y == 10'(V_ACTIVE));
    assign tick       = vb & ~vb_q;
    assign start_rise = start & ~start_q;

    always_comb begin
        page_d    = page_q;
        level_d   = level_q;
        hold_d    = hold_q;
        go_req_d  = go_req_q;
        adv_req_d = adv_req_q;
        xfer      = 1'b0;

        if (tick) begin
            unique case (page_q)
                PAGE_TITLE: begin
                    if (go_req_q) begin
                        page_d  = PAGE_LEVEL;
                        level_d = 3'd0;
                    end
                end
                PAGE_LEVEL: begin
                    if (adv_req_q) begin
                        if (level_q == LAST_LEVEL) begin
                            page_d = PAGE_DONE;
                            hold_d = '0;
                        end else begin
                            level_d = level_q + 3'd1;
                        end
                    end
                end
                PAGE_DONE: begin
                    // A start press beats the hold timer.
                    if (go_req_q || (hold_q == HOLD_LAST)) begin
                        page_d  = PAGE_TITLE;
                        level_d = 3'd0;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + CW'(1);
                    end
                end
                default: begin
                    page_d  = PAGE_TITLE;
                    level_d = 3'd0;
                    hold_d  = '0;
                end
            endcase

            xfer = (page_d != page_q) || (level_d != level_q);
            if (xfer) begin
                go_req_d  = 1'b0;
                adv_req_d = 1'b0;
            end
            if (page_q == PAGE_DONE) begin
                go_req_d = 1'b0;
            end
        end

        // Events are filed against the page that holds after this clock, so a
        // request landing on the tick cycle counts toward the next frame only.
        if (start_rise && (page_d == PAGE_TITLE || page_d == PAGE_DONE)) begin
            go_req_d = 1'b1;
        end
        if (level_solved && (page_d == PAGE_LEVEL)) begin
            adv_req_d = 1'b1;
        end

        changed_d = xfer;

        rgb_d = 12'h000;
        if (video_on) begin
            unique case (page_q)
                PAGE_TITLE: rgb_d = rgb_title;
                PAGE_LEVEL: rgb_d = rgb_level;
                PAGE_DONE:  rgb_d = rgb_done;
                default:    rgb_d = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            page_q    <= PAGE_TITLE;
            level_q   <= 3'd0;
            hold_q    <= '0;
            go_req_q  <= 1'b0;
            adv_req_q <= 1'b0;
            changed_q <= 1'b0;
            rgb_q     <= 12'h000;
            vb_q      <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            page_q    <= page_d;
            level_q   <= level_d;
            hold_q    <= hold_d;
            go_req_q  <= go_req_d;
            adv_req_q <= adv_req_d;
            changed_q <= changed_d;
            rgb_q     <= rgb_d;
            vb_q      <= vb;
            start_q   <= start;
        end
    end

    assign rgb          = rgb_q;
    assign page         = page_q;
    assign level        = level_q;
    assign page_changed = changed_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Testbench for screen_sequencer: directed scenarios plus random events,
// checked each cycle against a frame-level reference model.
module tb_screen_sequencer;

    localparam int NL = 3;
    localparam int HF = 4;
    localparam int VA = 480;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        start;
    logic        level_solved;
    logic [11:0] rgb_title;
    logic [11:0] rgb_level;
    logic [11:0] rgb_done;
    logic [11:0] rgb;
    logic [1:0]  page;
    logic [2:0]  level;
    logic        page_changed;

    screen_sequencer #(
        .NUM_LEVELS(NL),
        .DONE_HOLD_FRAMES(HF),
        .V_ACTIVE(VA)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .video_on(video_on),
        .x(x),
        .y(y),
        .start(start),
        .level_solved(level_solved),
        .rgb_title(rgb_title),
        .rgb_level(rgb_level),
        .rgb_done(rgb_done),
        .rgb(rgb),
        .page(page),
        .level(level),
        .page_changed(page_changed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int chg_seen = 0;
    bit fix_rgb = 0;
    bit rnd_vo = 0;

    // Reference model state: page as 0/1/2, level index, frames spent in
    // DONE, pending requests, previous blank/start samples.
    int m_page, m_level, m_frames;
    bit m_go, m_adv, m_vb, m_start, m_chg;
    int m_rgb;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_page = 0; m_level = 0; m_frames = 0;
        m_go = 0; m_adv = 0; m_vb = 0; m_start = 0; m_chg = 0;
        m_rgb = 0;
    endtask

    task automatic model_step();
        bit vb, tick, rise;
        int np, nl;
        vb   = (x == 0) && (y == VA);
        tick = vb && !m_vb;
        rise = start && !m_start;
        m_vb = vb;
        m_start = start;
        if (!video_on) m_rgb = 0;
        else if (m_page == 0) m_rgb = int'(rgb_title);
        else if (m_page == 1) m_rgb = int'(rgb_level);
        else m_rgb = int'(rgb_done);
        m_chg = 0;
        if (tick) begin
            np = m_page;
            nl = m_level;
            if (m_page == 0) begin
                if (m_go) begin np = 1; nl = 0; end
            end else if (m_page == 1) begin
                if (m_adv) begin
                    if (m_level + 1 < NL) nl = m_level + 1;
                    else begin np = 2; m_frames = 0; end
                end
            end else begin
                if (m_go || m_frames + 1 == HF) begin
                    np = 0; nl = 0; m_frames = 0;
                end else begin
                    m_frames++;
                end
            end
            m_chg = (np != m_page) || (nl != m_level);
            if (m_chg) begin m_go = 0; m_adv = 0; end
            if (m_page == 2) m_go = 0;
            m_page = np;
            m_level = nl;
        end
        if (rise && m_page != 1) m_go = 1;
        if (level_solved && m_page == 1) m_adv = 1;
    endtask

    task automatic check_all();
        chk("page", 32'(page), 32'(m_page));
        chk("level", 32'(level), 32'(m_level));
        chk("page_changed", 32'(page_changed), 32'(m_chg));
        chk("rgb", 32'(rgb), 32'(m_rgb));
        if (page_changed) chg_seen++;
    endtask

    task automatic cyc(input int xx, input int yy);
        x = 10'(xx);
        y = 10'(yy);
        video_on = rnd_vo ? 1'($urandom_range(0, 1)) : (yy < VA);
        if (!fix_rgb) begin
            rgb_title = 12'($urandom);
            rgb_level = 12'($urandom);
            rgb_done  = 12'($urandom);
        end
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic vis(input int n);
        for (int i = 0; i < n; i++) cyc(i + 1, 100);
    endtask

    task automatic tk();
        cyc(0, VA);
    endtask

    task automatic post();
        cyc(0, VA);
        cyc(1, VA);
        cyc(2, VA + 1);
    endtask

    task automatic frame();
        vis(6);
        tk();
        post();
    endtask

    task automatic start_frame();
        vis(2);
        start = 1'b1;
        cyc(3, 100);
        start = 1'b0;
        vis(2);
        tk();
        post();
    endtask

    task automatic solve_frame();
        vis(2);
        level_solved = 1'b1;
        cyc(3, 100);
        level_solved = 1'b0;
        vis(2);
        tk();
        post();
    endtask

    initial begin
        reset_n = 1'b0;
        video_on = 1'b0;
        x = '0;
        y = '0;
        start = 1'b0;
        level_solved = 1'b0;
        rgb_title = '0;
        rgb_level = '0;
        rgb_done = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_page", 32'(page), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rgb", 32'(rgb), 32'h000);
        chk("rst_chg", 32'(page_changed), 32'd0);
        reset_n = 1'b1;

        // Idle frames
        repeat (3) frame();
        chk("idle_page", 32'(page), 32'd0);
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_no_chg", 32'(chg_seen), 32'd0);

        fix_rgb = 1'b1;
        rgb_title = 12'h0F0;
        rgb_level = 12'h00F;
        rgb_done  = 12'hF00;
        cyc(5, 100);
        chk("title_rgb", 32'(rgb), 32'h0F0);
        fix_rgb = 1'b0;

        // Start in TITLE waits for the tick
        vis(3);
        start = 1'b1;
        cyc(3, 100);
        start = 1'b0;
        vis(3);
        chk("start_wait_page", 32'(page), 32'd0);
        tk();
        chk("start_tick_page", 32'(page), 32'd1);
        chk("start_tick_level", 32'(level), 32'd0);
        chk("start_tick_chg", 32'(page_changed), 32'd1);
        cyc(0, VA);
        chk("start_chg_1cyc", 32'(page_changed), 32'd0);
        cyc(1, VA);
        cyc(2, VA + 1);
        start = 1'b1;
        repeat (5) frame();
        start = 1'b0;
        chk("held_start_page", 32'(page), 32'd1);
        chk("held_start_level", 32'(level), 32'd0);

        // Two solves in one frame advance once
        vis(2);
        level_solved = 1'b1;
        cyc(3, 100);
        level_solved = 1'b0;
        cyc(4, 100);
        level_solved = 1'b1;
        cyc(5, 100);
        level_solved = 1'b0;
        vis(2);
        chk("dbl_solve_wait", 32'(level), 32'd0);
        tk();
        chk("dbl_solve_level", 32'(level), 32'd1);
        post();
        solve_frame();
        chk("solve2_level", 32'(level), 32'd2);
        chk("solve2_page", 32'(page), 32'd1);
        solve_frame();
        chk("done_page", 32'(page), 32'd2);
        chk("done_level", 32'(level), 32'd2);

        // Hold timer returns to TITLE on the 4th tick
        repeat (3) frame();
        chk("hold3_page", 32'(page), 32'd2);
        frame();
        chk("hold_ret_page", 32'(page), 32'd0);
        chk("hold_ret_level", 32'(level), 32'd0);

        // Start during the second DONE frame
        start_frame();
        repeat (NL) solve_frame();
        chk("done2_page", 32'(page), 32'd2);
        frame();
        start_frame();
        chk("done_start_page", 32'(page), 32'd0);
        chk("done_start_level", 32'(level), 32'd0);

        // Solve on the tick cycle, start ignored in LEVEL
        start_frame();
        chk("lvl_again_page", 32'(page), 32'd1);
        vis(4);
        level_solved = 1'b1;
        tk();
        level_solved = 1'b0;
        chk("solve_on_tick", 32'(level), 32'd0);
        post();
        frame();
        chk("solve_next_tick", 32'(level), 32'd1);
        start_frame();
        chk("start_in_lvl_pg", 32'(page), 32'd1);
        chk("start_in_lvl_lv", 32'(level), 32'd1);

        // Async reset while holding in DONE with two frames elapsed
        solve_frame();
        solve_frame();
        chk("pre_rst_page", 32'(page), 32'd2);
        repeat (2) frame();
        vis(3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_page", 32'(page), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_rgb", 32'(rgb), 32'h000);
        chk("arst_chg", 32'(page_changed), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) frame();
        chk("post_rst_page", 32'(page), 32'd0);
        start_frame();
        chk("post_rst_go", 32'(page), 32'd1);

        // Random events, including ones landing on tick cycles
        rnd_vo = 1'b1;
        repeat (60) begin
            int n;
            n = $urandom_range(2, 10);
            for (int i = 0; i < n; i++) begin
                start = ($urandom_range(0, 3) == 0);
                level_solved = ($urandom_range(0, 4) == 0);
                cyc(i + 1, 100);
            end
            start = ($urandom_range(0, 3) == 0);
            level_solved = ($urandom_range(0, 4) == 0);
            tk();
            start = ($urandom_range(0, 3) == 0);
            level_solved = ($urandom_range(0, 4) == 0);
            post();
        end
        start = 1'b0;
        level_solved = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level page controller for the VGA game display. Owns the page FSM (title, level play, done/escaped) and sequences the current level index.
- Selects which page renderer's rgb reaches the VGA output.
- Changes page only at the start of vertical blanking, so no frame ever tears between two pages.
- Sits between the VGA sync counter, the page display modules and the game logic.

Parameters:
- NUM_LEVELS, 3, number of playable levels (1..8).
- DONE_HOLD_FRAMES, 600, frames the done page is held before auto-return to title (10 s at 60 Hz).
- V_ACTIVE, 480, first non-visible line; vblank starts at y == V_ACTIVE.

Ports:
- clk  in  1  system/pixel-domain clock
- reset_n  in  1  asynchronous active-low reset
- video_on  in  1  high inside the visible region
- x  in  10  current pixel column
- y  in  10  current pixel row
- start  in  1  debounced start button, level-sensitive; rising edge detected internally
- level_solved  in  1  one-cycle pulse from game logic when the current level is solved
- rgb_title  in  12  title page pixel colour
- rgb_level  in  12  level page pixel colour
- rgb_done  in  12  done page pixel colour
- rgb  out  12  registered output pixel colour
- page  out  2  current page: 0 TITLE, 1 LEVEL, 2 DONE (3 never driven)
- level  out  3  current level index, 0-based
- page_changed  out  1  one-cycle pulse on the clock the page or level register updates

Behaviour:
- Reset state (async, immediate, also mid-frame or mid-hold):
  - page=TITLE, level=0, rgb=12'h000, page_changed=0.
  - Hold counter=0, pending flags clear, start/vblank edge registers cleared.
- Frame tick:
  - vb = (x==0 && y==V_ACTIVE), registered as vb_d.
  - tick = vb & ~vb_d: exactly one cycle per frame, regardless of how many clocks x stays 0.
- start_rise = start & ~start_d (start_d reset to 0).
- Pending requests are sticky flags, set between ticks and consumed only on tick:
  - go_req: set by start_rise when page==TITLE or page==DONE.
  - adv_req: set by level_solved when page==LEVEL. Multiple pulses within one frame yield a single advance.
  - Events that do not match the current page are ignored and set nothing. Examples: start in LEVEL; level_solved in TITLE or DONE.
- Transitions on tick, with all register updates on that same clock:
  - TITLE & go_req -> LEVEL, level=0.
  - LEVEL & adv_req & level<NUM_LEVELS-1 -> LEVEL, level=level+1.
  - LEVEL & adv_req & level==NUM_LEVELS-1 -> DONE, level unchanged, hold counter=0.
  - DONE:
    - go_req -> TITLE, level=0. go_req wins over the hold counter.
    - Otherwise hold counter +1.
    - When the counter reaches DONE_HOLD_FRAMES-1 on a tick -> TITLE, level=0, counter=0.
  - Any tick without a request: no change. The hold counter runs only in DONE.
- Pending flag timing:
  - Both flags clear on every tick that performs a transition.
  - go_req also clears on a tick in DONE.
  - An event arriving in the same cycle as tick is recorded for the next frame, not the current one.
- page_changed: 1 on the cycle page or level is written by a transition, else 0.
- rgb pipeline, 1-cycle latency registered on clk:
  - rgb = 12'h000 if ~video_on.
  - Otherwise rgb = rgb_title, rgb_level or rgb_done selected by the page register value in that cycle.
- The hold counter is ceil(log2(DONE_HOLD_FRAMES)) bits wide and never wraps. It saturates into the transition.

Test Plan:
- Reset then 3 frames with no stimulus -> page=0, level=0, page_changed never 1; with rgb_title=12'h0F0 and video_on=1, rgb=12'h0F0 one cycle later.
- start pulse at y=100 in TITLE -> page stays 0 until the tick at (x=0, y=480), then page=1, level=0, page_changed high exactly 1 cycle; start held high 5 frames causes no further change.
- In LEVEL with NUM_LEVELS=3: two level_solved pulses in one frame -> level 0->1 only at the next tick; one pulse per frame for 2 more frames -> level 2, then page=2 (DONE), level stays 2.
- DONE_HOLD_FRAMES=4, no start -> page returns to 0 on the 4th tick after entering DONE, level=0; with a start pulse during frame 2 instead -> page=0 at the tick ending frame 2.
- level_solved asserted on the exact tick cycle -> no change on that tick, advance on the following tick. start pulses while page=1 -> ignored.
- reset_n pulled low mid-frame while in DONE with counter=2 -> page=0, level=0, rgb=12'h000 immediately without waiting for a clock edge; after release the FSM behaves as from power-up.
